// File: rtl/accum_sched_pkg.sv
// accum_pkg: scheduler state encoding and default geometry shared with the accumulator
//   TRATE_DEF        bins per frame
//   RATE_BITS_DEF    log2 of passes per integration
//   FLUSH_CYCLES_DEF accumulator pipeline drain depth
package accum_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam int TRATE_DEF        = 8;
    localparam int RATE_BITS_DEF    = 3;
    localparam int FLUSH_CYCLES_DEF = 2;
endpackage

// File: rtl/accum_sched_if.sv
// accum_sched_if: sample handshake (upstream) and accumulator command bus
//   valid_i/ready_o           upstream sample handshake
//   acc_valid_o/acc_ready_i   accumulator handshake
//   acc_bin_o                 bin address of the current sample
//   acc_first_o/acc_last_o    clear / dump pass flags
//   slave = scheduler side, master = upstream + accumulator side
interface accum_sched_if #(parameter int LOG_TRATE = 3);
    logic                 valid_i;
    logic                 ready_o;
    logic                 acc_valid_o;
    logic                 acc_ready_i;
    logic [LOG_TRATE-1:0] acc_bin_o;
    logic                 acc_first_o;
    logic                 acc_last_o;
    modport slave (
        input  valid_i, acc_ready_i,
        output ready_o, acc_valid_o, acc_bin_o, acc_first_o, acc_last_o
    );
    modport master (
        output valid_i, acc_ready_i,
        input  ready_o, acc_valid_o, acc_bin_o, acc_first_o, acc_last_o
    );
endinterface

// File: rtl/accum_sched_cnt.sv
// accum_sched_cnt: bin/pass wrap counter pair with terminal-count output
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           synchronous clear of both counters (wins over i_inc)
//   i_inc           advance bin; pass advances when bin wraps
//   o_bin, o_pass   current bin and pass
//   o_tc            high at the last bin of the last pass
module accum_sched_cnt #(
    parameter int TRATE     = 8,
    parameter int LOG_TRATE = 3,
    parameter int RATE_BITS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [LOG_TRATE-1:0] o_bin,
    output logic [RATE_BITS-1:0] o_pass,
    output logic                 o_tc
);
    logic [LOG_TRATE-1:0] r_bin;
    logic [RATE_BITS-1:0] r_pass;
    logic                 w_wrap;

    assign w_wrap = r_bin == LOG_TRATE'(TRATE - 1);
    assign o_tc   = w_wrap & (&r_pass);
    assign o_bin  = r_bin;
    assign o_pass = r_pass;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin  <= '0;
            r_pass <= '0;
        end else if (i_clr) begin
            r_bin  <= '0;
            r_pass <= '0;
        end else if (i_inc) begin
            r_bin  <= w_wrap ? '0 : r_bin + LOG_TRATE'(1);
            r_pass <= r_pass + RATE_BITS'(w_wrap);
        end
    end
endmodule

// File: rtl/accum_sched.sv
// accum_sched: schedules TRATE-bin x NPASS-pass integrations into an accumulator
//   clock_i, reset_ni  clock, async active-low reset
//   enable_i           run enable; low stalls RUN but not FLUSH
//   start_i            begin one integration (honoured only in IDLE)
//   continuous_i       restart automatically after each integration
//   bus                sample/accumulator handshake (slave modport)
//   busy_o             not IDLE
//   done_o             one-cycle pulse on the final FLUSH cycle
//   frames_o           completed-integration count, wraps at 2^16
module accum_sched
    import accum_pkg::*;
#(
    parameter int TRATE        = TRATE_DEF,
    parameter int LOG_TRATE    = 3,
    parameter int RATE_BITS    = RATE_BITS_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               enable_i,
    input  logic               start_i,
    input  logic               continuous_i,
    accum_sched_if.slave       bus,
    output logic               busy_o,
    output logic               done_o,
    output logic [15:0]        frames_o
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    state_t               r_state, w_next;
    logic [FW-1:0]        r_flush;
    logic [15:0]          r_frames;
    logic                 w_run, w_flush, w_flush_last, w_hs, w_clr, w_tc;
    logic [LOG_TRATE-1:0] w_bin;
    logic [RATE_BITS-1:0] w_pass;

    assign w_run        = r_state == RUN;
    assign w_flush      = r_state == FLUSH;
    assign w_flush_last = w_flush && r_flush == FW'(FLUSH_CYCLES - 1);

    assign bus.ready_o     = w_run & bus.acc_ready_i & enable_i;
    assign bus.acc_valid_o = w_run & bus.valid_i & enable_i;
    assign w_hs            = bus.valid_i & bus.ready_o;

    assign bus.acc_bin_o   = w_bin;
    assign bus.acc_first_o = w_run & (w_pass == '0);
    assign bus.acc_last_o  = w_run & (&w_pass);

    assign busy_o   = r_state != IDLE;
    assign done_o   = w_flush_last;
    assign frames_o = r_frames;

    accum_sched_cnt #(
        .TRATE     (TRATE),
        .LOG_TRATE (LOG_TRATE),
        .RATE_BITS (RATE_BITS)
    ) u_cnt (
        .i_clk   (clock_i),
        .i_rst_n (reset_ni),
        .i_clr   (w_clr),
        .i_inc   (w_hs),
        .o_bin   (w_bin),
        .o_pass  (w_pass),
        .o_tc    (w_tc)
    );

    // Counters are cleared on every entry to RUN so a continuous restart
    // never inherits state from the previous integration.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && enable_i) begin
                    w_next = RUN;
                    w_clr  = 1'b1;
                end
            end
            RUN: begin
                if (w_hs && w_tc) w_next = FLUSH;
            end
            FLUSH: begin
                if (w_flush_last) begin
                    w_next = (continuous_i && enable_i) ? RUN : IDLE;
                    w_clr  = continuous_i && enable_i;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The flush counter ignores enable_i: the accumulator drains regardless.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state  <= IDLE;
            r_flush  <= '0;
            r_frames <= '0;
        end else begin
            r_state  <= w_next;
            r_flush  <= (w_flush && !w_flush_last) ? r_flush + FW'(1) : '0;
            r_frames <= r_frames + 16'(w_flush_last);
        end
    end
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: directed self-checking bench for accum_sched (TRATE=8, NPASS=8, FLUSH_CYCLES=2)
module tb_accum_sched;
    logic        clk = 1'b0;
    logic        reset_ni, enable_i, start_i, continuous_i;
    logic        busy_o, done_o;
    logic [15:0] frames_o;
    int          checks = 0;
    int          errors = 0;

    accum_sched_if #(.LOG_TRATE(3)) bus ();

    accum_sched #(
        .TRATE        (8),
        .LOG_TRATE    (3),
        .RATE_BITS    (3),
        .FLUSH_CYCLES (2)
    ) dut (
        .clock_i      (clk),
        .reset_ni     (reset_ni),
        .enable_i     (enable_i),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .bus          (bus),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .frames_o     (frames_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n handshakes with valid/ready/enable high; base = index of the first one
    task automatic hs_run(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("hs_ready", 32'(bus.ready_o), 32'd1);
            chk("hs_acc_valid", 32'(bus.acc_valid_o), 32'd1);
            chk("hs_bin", 32'(bus.acc_bin_o), 32'((base + k) % 8));
            chk("hs_first", 32'(bus.acc_first_o), 32'((base + k) < 8));
            chk("hs_last", 32'(bus.acc_last_o), 32'((base + k) >= 56));
            cyc();
        end
    endtask

    task automatic flush_chk(input int f);
        #1;
        chk("fl1_done", 32'(done_o), 32'd0);
        chk("fl1_busy", 32'(busy_o), 32'd1);
        chk("fl1_ready", 32'(bus.ready_o), 32'd0);
        chk("fl1_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        chk("fl1_frames", 32'(frames_o), 32'(f - 1));
        cyc();
        #1;
        chk("fl2_done", 32'(done_o), 32'd1);
        chk("fl2_busy", 32'(busy_o), 32'd1);
        chk("fl2_frames", 32'(frames_o), 32'(f - 1));
        cyc();
        #1;
        chk("fl3_done", 32'(done_o), 32'd0);
        chk("fl3_busy", 32'(busy_o), 32'd0);
        chk("fl3_frames", 32'(frames_o), 32'(f));
    endtask

    initial begin
        int n, runc, dn;
        bit fin;
        reset_ni        = 1'b0;
        enable_i        = 1'b1;
        start_i         = 1'b0;
        continuous_i    = 1'b0;
        bus.valid_i     = 1'b1;
        bus.acc_ready_i = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_frames", 32'(frames_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        chk("rst_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        chk("rst_bin", 32'(bus.acc_bin_o), 32'd0);
        chk("rst_first", 32'(bus.acc_first_o), 32'd0);
        chk("rst_last", 32'(bus.acc_last_o), 32'd0);
        cyc();
        cyc();
        reset_ni = 1'b1;
        cyc();
        cyc();
        #1;
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_ready", 32'(bus.ready_o), 32'd0);

        // single integration, start held high for the first pass
        start_i = 1'b1;
        cyc();
        hs_run(8, 0);
        start_i = 1'b0;
        hs_run(56, 8);
        flush_chk(1);

        // acc_ready_i toggling, starting low on the first RUN cycle
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        n = 0; runc = 0; dn = 0; fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            bus.acc_ready_i = i[0];
            #1;
            if (bus.acc_valid_o) runc++;
            if (done_o) dn++;
            if (bus.valid_i && bus.ready_o) begin
                chk("tog_bin", 32'(bus.acc_bin_o), 32'(n % 8));
                n++;
            end
            if (!busy_o) fin = 1;
            cyc();
        end
        bus.acc_ready_i = 1'b1;
        chk("tog_finished", 32'(fin), 32'd1);
        chk("tog_hs", 32'(n), 32'd64);
        chk("tog_run_cycles", 32'(runc), 32'd128);
        chk("tog_dones", 32'(dn), 32'd1);
        chk("tog_frames", 32'(frames_o), 32'd2);

        // enable low for 10 cycles at bin=5 pass=3, then low again through FLUSH
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        hs_run(29, 0);
        enable_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("en_ready", 32'(bus.ready_o), 32'd0);
            chk("en_acc_valid", 32'(bus.acc_valid_o), 32'd0);
            chk("en_bin", 32'(bus.acc_bin_o), 32'd5);
            chk("en_busy", 32'(busy_o), 32'd1);
            cyc();
        end
        enable_i = 1'b1;
        hs_run(35, 29);
        enable_i = 1'b0;
        flush_chk(3);
        enable_i = 1'b1;

        // continuous mode: three back-to-back integrations, start during RUN ignored
        continuous_i = 1'b1;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (r == 1) start_i = 1'b1;
            hs_run(64, 0);
            start_i = 1'b0;
            #1;
            chk("ct_fl1_done", 32'(done_o), 32'd0);
            chk("ct_fl1_busy", 32'(busy_o), 32'd1);
            cyc();
            #1;
            chk("ct_fl2_done", 32'(done_o), 32'd1);
            chk("ct_fl2_frames", 32'(frames_o), 32'(3 + r));
            if (r == 2) continuous_i = 1'b0;
            cyc();
            #1;
            chk("ct_after_busy", 32'(busy_o), 32'(r < 2));
            chk("ct_after_done", 32'(done_o), 32'd0);
            chk("ct_after_frames", 32'(frames_o), 32'(4 + r));
            if (r < 2) chk("ct_after_first", 32'(bus.acc_first_o), 32'd1);
        end

        // reset at pass 4 aborts the integration
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        hs_run(32, 0);
        #1;
        chk("ab_first", 32'(bus.acc_first_o), 32'd0);
        chk("ab_last", 32'(bus.acc_last_o), 32'd0);
        chk("ab_acc_valid", 32'(bus.acc_valid_o), 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_done", 32'(done_o), 32'd0);
        chk("ab_frames", 32'(frames_o), 32'd0);
        chk("ab_ready", 32'(bus.ready_o), 32'd0);
        chk("ab_acc_valid0", 32'(bus.acc_valid_o), 32'd0);
        chk("ab_bin", 32'(bus.acc_bin_o), 32'd0);
        chk("ab_first0", 32'(bus.acc_first_o), 32'd0);
        chk("ab_last0", 32'(bus.acc_last_o), 32'd0);
        cyc();
        reset_ni = 1'b1;
        cyc();
        cyc();
        #1;
        chk("ab_idle_busy", 32'(busy_o), 32'd0);
        chk("ab_idle_done", 32'(done_o), 32'd0);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        hs_run(64, 0);
        flush_chk(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
